// File: rtl/push_btn_click_decoder.sv
// Groups one-cycle debounced button presses into multi-click gestures and
// offers the finished click count on a valid/ready port.
module push_btn_click_decoder #(
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned TIMER_WIDTH = 8,
  parameter int unsigned MAX_CLICKS  = 3,
  parameter int unsigned COUNT_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   button_pressed,
  input  logic                   click_ready,
  output logic                   click_valid,
  output logic [COUNT_WIDTH-1:0] click_count,
  output logic                   click_dropped,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    REPORT   = 2'd2
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] GAP_LOAD  = TIMER_WIDTH'(GAP_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = COUNT_WIDTH'(MAX_CLICKS);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

  // A single-click gesture is already saturated on its first press.
  localparam state_t START_STATE = (MAX_CLICKS == 1) ? REPORT : COUNTING;

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
  logic                     valid_d;
  logic [COUNT_WIDTH-1:0]   click_count_d;
  logic                     dropped_d;
  logic                     busy_d;

  // State, gesture bookkeeping and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      timer_q       <= '0;
      click_valid   <= 1'b0;
      click_count   <= '0;
      click_dropped <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      click_valid   <= valid_d;
      click_count   <= click_count_d;
      click_dropped <= dropped_d;
      busy          <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    dropped_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (button_pressed) begin
          state_d = START_STATE;
          count_d = CNT_ONE;
          timer_d = GAP_LOAD;
        end
      end

      COUNTING: begin
        // A press on the expiry edge still belongs to the gesture.
        if (button_pressed) begin
          if (count_q + CNT_ONE == CNT_MAX) begin
            state_d = REPORT;
            count_d = CNT_MAX;
            timer_d = '0;
          end else begin
            count_d = count_q + CNT_ONE;
            timer_d = GAP_LOAD;
          end
        end else if (timer_q <= TIMER_ONE) begin
          state_d = REPORT;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      REPORT: begin
        if (click_ready) begin
          if (button_pressed) begin
            state_d = START_STATE;
            count_d = CNT_ONE;
            timer_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
            count_d = '0;
            timer_d = '0;
          end
        end else if (button_pressed) begin
          dropped_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        timer_d = '0;
      end
    endcase

    valid_d       = (state_d == REPORT);
    click_count_d = valid_d ? count_d : '0;
    busy_d        = (state_d != IDLE);
  end

endmodule
